// File: rtl/mem_image_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_image_loader                                                           |
// | Framed LE byte-stream loader (LEN | N data words | CSUM) into a byte-lane   |
// | SRAM; holds the CPU in reset until the image is written and verified.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_image_loader #(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_sram_cs,
  output logic [3:0]        o_sram_web,
  output logic [ADDR_W-1:0] o_sram_a,
  output logic [31:0]       o_sram_di,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_words_wr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // Number of words that fit between BASE_ADDR and the top of the SRAM.
  localparam logic [32:0] c_MAX_WORDS = 33'(2**ADDR_W) - 33'(BASE_ADDR);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [1:0]        r_idx;
  logic [31:0]       r_shift;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_words;
  logic [31:0]       r_csum;
  logic [ADDR_W-1:0] r_sram_a;
  logic [31:0]       r_sram_di;

  logic              w_xfer;
  logic              w_last_byte;
  logic [31:0]       w_word;
  logic              w_start_ok;
  logic [ADDR_W:0]   w_words_inc;
  logic              w_overflow;

  assign w_xfer      = i_in_valid & o_in_ready;
  assign w_last_byte = w_xfer & (r_idx == 2'd3);
  assign w_word      = {i_in_data, r_shift[31:8]};
  assign w_start_ok  = i_start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_words_inc = r_words + 1'b1;
  assign w_overflow  = {1'b0, w_word} > c_MAX_WORDS;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LEN;
      S_LEN: begin
        if (w_last_byte) begin
          if (w_overflow)            w_next = S_ERR;
          else if (w_word == 32'd0)  w_next = S_CSUM;
          else                       w_next = S_DATA;
        end
      end
      S_DATA:  if (w_last_byte) w_next = S_WRITE;
      S_WRITE: w_next = (w_words_inc == r_len) ? S_CSUM : S_DATA;
      S_CSUM:  if (w_last_byte) w_next = (w_word == r_csum) ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:   if (i_start) w_next = S_LEN;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (r_state == S_LEN) | (r_state == S_DATA) | (r_state == S_CSUM);
    o_sram_cs  = (r_state == S_WRITE);
    o_sram_web = (r_state == S_WRITE) ? 4'b0000 : 4'b1111;
    o_cpu_hold = (r_state != S_DONE);
    o_done     = (r_state == S_DONE);
    o_error    = (r_state == S_ERR);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx     <= 2'd0;
      r_shift   <= 32'd0;
      r_len     <= '0;
      r_words   <= '0;
      r_csum    <= 32'd0;
      r_sram_a  <= '0;
      r_sram_di <= 32'd0;
    end else begin
      if (w_start_ok) begin
        r_idx   <= 2'd0;
        r_words <= '0;
        r_csum  <= 32'd0;
      end
      if (w_xfer) begin
        r_shift <= w_word;
        r_idx   <= r_idx + 2'd1;
      end
      if ((r_state == S_LEN) && w_last_byte && !w_overflow) begin
        r_len <= w_word[ADDR_W:0];
      end
      // Address and data are captured with the 4th byte so they are stable for the whole WRITE cycle.
      if ((r_state == S_DATA) && w_last_byte) begin
        r_sram_a  <= BASE_ADDR + r_words[ADDR_W-1:0];
        r_sram_di <= w_word;
      end
      if (r_state == S_WRITE) begin
        r_words <= w_words_inc;
        r_csum  <= r_csum + r_sram_di;
      end
    end
  end

  assign o_sram_a   = r_sram_a;
  assign o_sram_di  = r_sram_di;
  assign o_words_wr = r_words;

endmodule
`default_nettype wire
